// File: rtl/tcam2_ctrl.sv
// tcam2_ctrl: command front-end for a TCAM with separate write and read ports.
//
// Accepts single commands over a valid/ready handshake and turns them into
// TCAM port activity:
//   op 00 write : one write of (data, mask) to addr
//   op 01 read  : one read request to addr, result returned on rsp_*
//   op 10 fill  : writes (data, mask) to every entry, addresses 0..ITEMS-1
//   op 11       : reserved, answered with a one-cycle err pulse
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   cmd_op/addr/data/mask       command fields, captured on cmd_vld & cmd_rdy
//   cmd_vld / cmd_rdy           command handshake (cmd_rdy only in IDLE)
//   write_addr/data/mask/en     TCAM write port, write_rdy accepts
//   read_addr/en, read_rdy      TCAM read request port
//   read_data/mask/data_vld     TCAM read response
//   rsp_data/mask/vld           read result, no backpressure
//   done, err, busy             completion pulse, reserved-op pulse, not-idle
//
// Every output is either a register or a decode of the state register, so
// there is no combinational path from any input to any output.
module tcam2_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ITEMS      = 16,
  localparam int ADDR_WIDTH = $clog2(ITEMS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] write_mask,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  write_en,
  input  logic                  write_rdy,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  read_en,
  input  logic                  read_rdy,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic [DATA_WIDTH-1:0] read_mask,
  input  logic                  read_data_vld,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [DATA_WIDTH-1:0] rsp_mask,
  output logic                  rsp_vld,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ITEMS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    FILL    = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] mask_reg;
  logic [ADDR_WIDTH-1:0] fill_cnt_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;
  logic [DATA_WIDTH-1:0] rsp_mask_reg;
  logic                  rsp_vld_reg;
  logic                  done_reg;
  logic                  err_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_vld) begin
          case (cmd_op)
            2'b00:   state_next = WR;
            2'b01:   state_next = RD_REQ;
            2'b10:   state_next = FILL;
            default: state_next = IDLE;  // reserved: err pulse only
          endcase
        end
      end
      WR:      if (write_rdy) state_next = IDLE;
      RD_REQ:  if (read_rdy) state_next = RD_WAIT;
      RD_WAIT: if (read_data_vld) state_next = IDLE;
      FILL:    if (write_rdy && (fill_cnt_reg == LAST_ADDR)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: command capture, fill counter, response and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg     <= '0;
      data_reg     <= '0;
      mask_reg     <= '0;
      fill_cnt_reg <= '0;
      rsp_data_reg <= '0;
      rsp_mask_reg <= '0;
      rsp_vld_reg  <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless re-armed below.
      rsp_vld_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_vld) begin
            addr_reg <= cmd_addr;
            data_reg <= cmd_data;
            mask_reg <= cmd_mask;
            if (cmd_op == 2'b10) fill_cnt_reg <= '0;
            if (cmd_op == 2'b11) err_reg <= 1'b1;
          end
        end
        WR: begin
          if (write_rdy) done_reg <= 1'b1;
        end
        RD_WAIT: begin
          // Response data is only captured here; stray valids elsewhere are
          // dropped so rsp_* keeps its last result.
          if (read_data_vld) begin
            rsp_data_reg <= read_data;
            rsp_mask_reg <= read_mask;
            rsp_vld_reg  <= 1'b1;
            done_reg     <= 1'b1;
          end
        end
        FILL: begin
          if (write_rdy) begin
            // Stop at the last entry instead of wrapping back to 0.
            if (fill_cnt_reg == LAST_ADDR) begin
              done_reg <= 1'b1;
            end else begin
              fill_cnt_reg <= fill_cnt_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state / registers only.
  assign cmd_rdy    = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign write_en   = (state_reg == WR) || (state_reg == FILL);
  assign read_en    = (state_reg == RD_REQ);
  assign write_addr = (state_reg == FILL) ? fill_cnt_reg : addr_reg;
  assign write_data = data_reg;
  assign write_mask = mask_reg;
  assign read_addr  = addr_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_mask   = rsp_mask_reg;
  assign rsp_vld    = rsp_vld_reg;
  assign done       = done_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_tcam2_ctrl.sv
// Directed testbench for tcam2_ctrl (DATA_WIDTH=16, ITEMS=16).
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at that same point, so each sample shows the state after the edge.
module tb_tcam2_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [DW-1:0] cmd_mask = '0;
  logic          cmd_vld = 1'b0;
  logic          cmd_rdy;
  logic [DW-1:0] write_data;
  logic [DW-1:0] write_mask;
  logic [AW-1:0] write_addr;
  logic          write_en;
  logic          write_rdy = 1'b0;
  logic [AW-1:0] read_addr;
  logic          read_en;
  logic          read_rdy = 1'b0;
  logic [DW-1:0] read_data = '0;
  logic [DW-1:0] read_mask = '0;
  logic          read_data_vld = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] rsp_mask;
  logic          rsp_vld;
  logic          done;
  logic          err;
  logic          busy;

  int tests = 0;
  int fails = 0;

  tcam2_ctrl #(.DATA_WIDTH(DW), .ITEMS(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_mask(cmd_mask), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .write_data(write_data), .write_mask(write_mask), .write_addr(write_addr),
    .write_en(write_en), .write_rdy(write_rdy),
    .read_addr(read_addr), .read_en(read_en), .read_rdy(read_rdy),
    .read_data(read_data), .read_mask(read_mask), .read_data_vld(read_data_vld),
    .rsp_data(rsp_data), .rsp_mask(rsp_mask), .rsp_vld(rsp_vld),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command for exactly one accepting edge (DUT must be in IDLE).
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] m);
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_vld = 1'b1;
    step();
    cmd_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    tests++;
    if ({write_en, read_en, rsp_vld, done, err, busy} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got we/re/rv/dn/er/bz=%b want 000000",
               {write_en, read_en, rsp_vld, done, err, busy});
    end
    tests++;
    if ({rsp_data, rsp_mask, write_data, write_mask} !== 64'h0 ||
        write_addr !== 4'h0 || read_addr !== 4'h0) begin
      fails++;
      $display("FAIL reset_data: got rsp=%h/%h wr=%h/%h wa=%h ra=%h want all 0",
               rsp_data, rsp_mask, write_data, write_mask, write_addr, read_addr);
    end
    step();
    rst = 1'b0;
    step();
    tests++;
    if (cmd_rdy !== 1'b1) begin
      fails++;
      $display("FAIL reset_cmd_rdy: got %b want 1", cmd_rdy);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_write();
    write_rdy = 1'b1;
    issue(2'b00, 4'd5, 16'h1234, 16'hFF00);
    tests++;
    if (write_en !== 1'b1 || write_addr !== 4'd5 || write_data !== 16'h1234 ||
        write_mask !== 16'hFF00 || busy !== 1'b1 || cmd_rdy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL write_issue: got en=%b a=%h d=%h m=%h bz=%b rdy=%b dn=%b want 1 5 1234 ff00 1 0 0",
               write_en, write_addr, write_data, write_mask, busy, cmd_rdy, done);
    end
    step();
    tests++;
    if (done !== 1'b1 || write_en !== 1'b0 || busy !== 1'b0 || cmd_rdy !== 1'b1) begin
      fails++;
      $display("FAIL write_done: got dn=%b en=%b bz=%b rdy=%b want 1 0 0 1",
               done, write_en, busy, cmd_rdy);
    end
    step();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL write_done_pulse: got %b want 0", done);
    end
    $display("[TB] write addr=5 data=1234 mask=ff00");
  endtask

  task automatic test_read();
    read_rdy = 1'b1;
    issue(2'b01, 4'd3, 16'h0, 16'h0);
    tests++;
    if (read_en !== 1'b1 || read_addr !== 4'd3 || write_en !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL read_req: got re=%b ra=%h we=%b bz=%b want 1 3 0 1",
               read_en, read_addr, write_en, busy);
    end
    step();
    tests++;
    if (read_en !== 1'b0 || busy !== 1'b1 || rsp_vld !== 1'b0) begin
      fails++;
      $display("FAIL read_wait: got re=%b bz=%b rv=%b want 0 1 0", read_en, busy, rsp_vld);
    end
    read_data = 16'hABCD; read_mask = 16'h00FF; read_data_vld = 1'b1;
    step();
    read_data_vld = 1'b0;
    tests++;
    if (rsp_vld !== 1'b1 || done !== 1'b1 || rsp_data !== 16'hABCD || rsp_mask !== 16'h00FF) begin
      fails++;
      $display("FAIL read_rsp: got rv=%b dn=%b d=%h m=%h want 1 1 abcd 00ff",
               rsp_vld, done, rsp_data, rsp_mask);
    end
    step();
    tests++;
    if (rsp_vld !== 1'b0 || done !== 1'b0 || rsp_data !== 16'hABCD) begin
      fails++;
      $display("FAIL read_rsp_pulse: got rv=%b dn=%b d=%h want 0 0 abcd", rsp_vld, done, rsp_data);
    end
    $display("[TB] read addr=3 -> abcd/00ff");
  endtask

  task automatic test_spurious();
    read_data = 16'h5555; read_mask = 16'h5555; read_data_vld = 1'b1;
    step();
    read_data_vld = 1'b0;
    tests++;
    if (rsp_vld !== 1'b0 || rsp_data !== 16'hABCD || rsp_mask !== 16'h00FF || busy !== 1'b0) begin
      fails++;
      $display("FAIL spurious_vld: got rv=%b d=%h m=%h bz=%b want 0 abcd 00ff 0",
               rsp_vld, rsp_data, rsp_mask, busy);
    end
    $display("[TB] spurious read_data_vld in idle");
  endtask

  task automatic test_reserved();
    issue(2'b11, 4'd0, 16'h0, 16'h0);
    tests++;
    if (err !== 1'b1 || cmd_rdy !== 1'b1 || write_en !== 1'b0 || read_en !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reserved_err: got er=%b rdy=%b we=%b re=%b bz=%b dn=%b want 1 1 0 0 0 0",
               err, cmd_rdy, write_en, read_en, busy, done);
    end
    step();
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL reserved_pulse: got %b want 0", err);
    end
    $display("[TB] reserved op 11");
  endtask

  // Fill with write_rdy alternating 0/1: the address must advance only on
  // cycles where the previous edge saw write_rdy=1.
  task automatic test_fill();
    int exp_addr;
    int ok;
    exp_addr = 0;
    ok = 0;
    write_rdy = 1'b0;
    issue(2'b10, 4'd9, 16'h0000, 16'h0000);
    for (int i = 0; i < 64; i++) begin
      if (exp_addr == 16) begin
        tests++;
        if (done !== 1'b1 || write_en !== 1'b0 || busy !== 1'b0) begin
          fails++;
          $display("FAIL fill_done: got dn=%b we=%b bz=%b want 1 0 0", done, write_en, busy);
        end
        ok = 1;
        break;
      end
      tests++;
      if (write_en !== 1'b1 || write_addr !== exp_addr[AW-1:0] || done !== 1'b0 ||
          write_data !== 16'h0 || write_mask !== 16'h0) begin
        fails++;
        $display("FAIL fill_write: cycle %0d got we=%b a=%h dn=%b want 1 %h 0",
                 i, write_en, write_addr, done, exp_addr[AW-1:0]);
      end
      write_rdy = (i % 2 == 1);
      step();
      if (write_rdy) exp_addr++;
    end
    write_rdy = 1'b0;
    tests++;
    if (ok == 0) begin
      fails++;
      $display("FAIL fill_timeout: got %0d writes want 16", exp_addr);
    end
    step();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL fill_single_done: got %b want 0", done);
    end
    $display("[TB] fill 16 entries with stalls");
  endtask

  task automatic test_reset_mid_fill();
    int ok;
    ok = 0;
    write_rdy = 1'b1;
    issue(2'b10, 4'd0, 16'hBEEF, 16'h0F0F);
    repeat (7) step();
    tests++;
    if (write_en !== 1'b1 || write_addr !== 4'd7) begin
      fails++;
      $display("FAIL midfill_addr: got we=%b a=%h want 1 7", write_en, write_addr);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (write_en !== 1'b0 || busy !== 1'b0 || write_addr !== 4'd0 || done !== 1'b0 ||
        write_data !== 16'h0 || cmd_rdy !== 1'b1) begin
      fails++;
      $display("FAIL midfill_async_rst: got we=%b bz=%b a=%h dn=%b d=%h rdy=%b want 0 0 0 0 0 1",
               write_en, busy, write_addr, done, write_data, cmd_rdy);
    end
    step();
    rst = 1'b0;
    step();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL midfill_no_done: got %b want 0", done);
    end
    write_rdy = 1'b0;
    issue(2'b10, 4'd0, 16'h1111, 16'h2222);
    tests++;
    if (write_en !== 1'b1 || write_addr !== 4'd0 || write_data !== 16'h1111) begin
      fails++;
      $display("FAIL refill_start: got we=%b a=%h d=%h want 1 0 1111", write_en, write_addr, write_data);
    end
    write_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    write_rdy = 1'b0;
    tests++;
    if (ok == 0) begin
      fails++;
      $display("FAIL refill_timeout: done not seen within 40 cycles");
    end
    $display("[TB] reset at fill address 7, refill from 0");
  endtask

  // Stalled write, back-to-back read issued on the done cycle, stalled
  // read request, then reset while waiting for the read response.
  task automatic test_back_to_back();
    write_rdy = 1'b0;
    issue(2'b00, 4'd10, 16'hCAFE, 16'h00F0);
    step();
    tests++;
    if (write_en !== 1'b1 || write_addr !== 4'd10 || write_data !== 16'hCAFE ||
        write_mask !== 16'h00F0 || done !== 1'b0) begin
      fails++;
      $display("FAIL wr_stall: got we=%b a=%h d=%h m=%h dn=%b want 1 a cafe 00f0 0",
               write_en, write_addr, write_data, write_mask, done);
    end
    write_rdy = 1'b1;
    step();
    write_rdy = 1'b0;
    tests++;
    if (done !== 1'b1 || cmd_rdy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_done_rdy: got dn=%b rdy=%b want 1 1", done, cmd_rdy);
    end
    read_rdy = 1'b0;
    issue(2'b01, 4'd12, 16'h0, 16'h0);
    step();
    tests++;
    if (read_en !== 1'b1 || read_addr !== 4'd12) begin
      fails++;
      $display("FAIL rd_stall: got re=%b ra=%h want 1 c", read_en, read_addr);
    end
    read_rdy = 1'b1;
    step();
    read_rdy = 1'b0;
    tests++;
    if (read_en !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_rd_wait: got re=%b bz=%b want 0 1", read_en, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    read_data = 16'h9999; read_mask = 16'h7777; read_data_vld = 1'b1;
    step();
    read_data_vld = 1'b0;
    tests++;
    if (rsp_vld !== 1'b0 || done !== 1'b0 || rsp_data !== 16'h0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midread_rst: got rv=%b dn=%b d=%h bz=%b want 0 0 0000 0",
               rsp_vld, done, rsp_data, busy);
    end
    $display("[TB] back-to-back write/read, reset during read wait");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_spurious();
    test_reserved();
    test_fill();
    test_reset_mid_fill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tcam2_ctrl.md
TCAM2_CTRL -- requirements
Module: tcam2_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of TCAM data and mask words.
REQ-002 Parameter ITEMS, default 16: number of TCAM entries; ADDR_WIDTH = log2(ITEMS), ITEMS SHALL be a power of two >= 2.
REQ-003 CLK  in  1: single clock; all logic SHALL be rising-edge CLK.
REQ-004 RST  in  1: asynchronous, active-high reset.
REQ-005 CMD_OP  in  2: command code; 00 write, 01 read, 10 fill, 11 reserved.
REQ-006 CMD_ADDR  in  ADDR_WIDTH: target entry for write/read.
REQ-007 CMD_DATA / CMD_MASK  in  DATA_WIDTH each: entry data and mask for write/fill.
REQ-008 CMD_VLD  in  1 / CMD_RDY  out  1: command handshake; transfer when both are 1.
REQ-009 WRITE_DATA, WRITE_MASK  out  DATA_WIDTH; WRITE_ADDR  out  ADDR_WIDTH; WRITE_EN  out  1; WRITE_RDY  in  1: TCAM write port; write accepted when WRITE_EN and WRITE_RDY are both 1.
REQ-010 READ_ADDR  out  ADDR_WIDTH; READ_EN  out  1; READ_RDY  in  1: TCAM read request port.
REQ-011 READ_DATA, READ_MASK  in  DATA_WIDTH; READ_DATA_VLD  in  1: TCAM read response.
REQ-012 RSP_DATA, RSP_MASK  out  DATA_WIDTH; RSP_VLD  out  1: read result to the command source; no backpressure.
REQ-013 DONE  out  1: one-cycle pulse on completion of any write, read or fill command.
REQ-014 ERR  out  1: one-cycle pulse when a reserved command is accepted.
REQ-015 BUSY  out  1: 1 whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, WR, RD_REQ, RD_WAIT and FILL.
REQ-017 CMD_RDY SHALL be 1 only in IDLE; on the accepting edge CMD_OP/ADDR/DATA/MASK SHALL be latched.
REQ-018 Transitions from IDLE on accept: op 00 -> WR, op 01 -> RD_REQ, op 10 -> FILL with fill counter = 0, op 11 -> stay IDLE with ERR=1 the next cycle.
REQ-019 WRITE_EN SHALL be 1 exactly in WR and FILL; READ_EN SHALL be 1 exactly in RD_REQ; first assertion SHALL be the cycle after command acceptance.
REQ-020 WR: WRITE_ADDR/DATA/MASK = latched values, held stable until WRITE_RDY; on WRITE_RDY -> IDLE with DONE=1 the next cycle.
REQ-021 RD_REQ: READ_ADDR = latched address; on READ_RDY -> RD_WAIT.
REQ-022 RD_WAIT: on READ_DATA_VLD, RSP_DATA/RSP_MASK SHALL register READ_DATA/READ_MASK and RSP_VLD and DONE SHALL pulse 1 for one cycle; FSM -> IDLE; no timeout, waits indefinitely.
REQ-023 READ_DATA_VLD outside RD_WAIT SHALL be ignored; RSP_* SHALL be unchanged.
REQ-024 FILL: WRITE_ADDR = fill counter, WRITE_DATA/MASK = latched values; each accepted write increments the counter; accepted write at ITEMS-1 -> IDLE with DONE=1 the next cycle; counter SHALL never wrap past ITEMS-1.
REQ-025 A fill SHALL issue exactly ITEMS writes to addresses 0..ITEMS-1 in ascending order, one per cycle when WRITE_RDY stays 1.
REQ-026 WRITE_RDY/READ_RDY low SHALL stall the current state with all port outputs held stable.
REQ-027 A new command is accepted in the cycle DONE/ERR is asserted (back-to-back), i.e. at most one idle cycle between commands.
REQ-028 All outputs SHALL be driven from registers or directly decoded from the state register (no input-to-output combinational path).

Reset
REQ-029 RST=1 SHALL asynchronously force state IDLE, fill counter 0, CMD_RDY=1 once RST deasserts, WRITE_EN=READ_EN=RSP_VLD=DONE=ERR=BUSY=0, RSP_DATA=RSP_MASK=0, WRITE_*/READ_ADDR=0.
REQ-030 RST mid-fill or mid-read SHALL abort the command with no DONE; a READ_DATA_VLD arriving after reset SHALL be ignored.

Verification
REQ-031 Write op 00, addr 5, data 0x1234, mask 0xFF00, WRITE_RDY=1 -> one WRITE_EN cycle with those values, DONE one cycle later, BUSY 1 for 1 cycle.
REQ-032 Read op 01, addr 3; READ_RDY=1; READ_DATA_VLD 2 cycles later with 0xABCD/0x00FF -> RSP_VLD one cycle with RSP_DATA=0xABCD, RSP_MASK=0x00FF, DONE coincident.
REQ-033 Fill op 10, data 0, mask 0, ITEMS=16, WRITE_RDY toggled 1/0 -> exactly 16 accepted writes, addresses 0..15 ascending, outputs stable while stalled, single DONE after address 15.
REQ-034 Op 11 -> ERR one cycle, no WRITE_EN/READ_EN, CMD_RDY back to 1 immediately.
REQ-035 Spurious READ_DATA_VLD in IDLE -> RSP_VLD stays 0, RSP_DATA unchanged.
REQ-036 RST asserted at fill address 7 -> all outputs to reset values asynchronously, no DONE, next fill restarts at address 0.
